// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator and pulse-counting blocks:
// FSM state encoding and default counter/duration widths.
package pulse_pkg;

  localparam int PULSE_CNT_W = 32;
  localparam int PULSE_DUR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } pulse_state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter: counts to zero and holds there. expire is high
// whenever the count reads zero.
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N pulses of H high / L low cycles on a
// registered output, with progress (sent), busy and a one-cycle done strobe.
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int CNT_W = PULSE_CNT_W,
  parameter int DUR_W = PULSE_DUR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [DUR_W-1:0] high_cycles,
  input  logic [DUR_W-1:0] low_cycles,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent
);

  pulse_state_t state, next_state;

  logic [CNT_W-1:0] n_cfg;
  logic [DUR_W-1:0] h_cfg;
  logic [DUR_W-1:0] l_cfg;

  logic             start_ok;
  logic [DUR_W-1:0] h_sel;
  logic [DUR_W-1:0] h_m1;
  logic [DUR_W-1:0] l_m1;
  logic             timer_load;
  logic [DUR_W-1:0] timer_value;
  logic             expire;

  assign start_ok = (state == ST_IDLE) && start;

  // The first high phase is loaded straight from the inputs, before they are latched.
  assign h_sel = start_ok ? high_cycles : h_cfg;
  // A zero duration behaves as one cycle, so the timer loads zero in both cases.
  assign h_m1  = (h_sel == '0) ? '0 : h_sel - 1'b1;
  assign l_m1  = (l_cfg == '0) ? '0 : l_cfg - 1'b1;

  phase_timer #(.W(DUR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .expire     (expire)
  );

  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = h_m1;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_pulses != '0) begin
            next_state = ST_HIGH;
            timer_load = 1'b1;
          end else begin
            next_state = ST_DONE;
          end
        end
      end
      ST_HIGH: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (expire) begin
          next_state  = ST_LOW;
          timer_load  = 1'b1;
          timer_value = l_m1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (expire) begin
          if (sent == n_cfg) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_HIGH;
            timer_load = 1'b1;
          end
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      n_cfg <= '0;
      h_cfg <= '0;
      l_cfg <= '0;
      sent  <= '0;
      pulse <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      // Outputs are registered from the next state so they align with it.
      pulse <= (next_state == ST_HIGH);
      busy  <= (next_state != ST_IDLE);
      done  <= (next_state == ST_DONE);
      if (start_ok) begin
        n_cfg <= num_pulses;
        h_cfg <= high_cycles;
        l_cfg <= low_cycles;
        sent  <= (num_pulses != '0) ? CNT_W'(1) : '0;
      end else if ((state == ST_LOW) && (next_state == ST_HIGH)) begin
        sent <= sent + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: cycle-by-cycle arithmetic model
// plus hand-computed directed expectations.
module tb_pulse_train_gen;
  import pulse_pkg::*;

  localparam int CW = 32;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] num_pulses;
  logic [DW-1:0] high_cycles;
  logic [DW-1:0] low_cycles;
  logic          pulse;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  bit     chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_train_gen #(.CNT_W(CW), .DUR_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .num_pulses  (num_pulses),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulse       (pulse),
    .busy        (busy),
    .done        (done),
    .sent        (sent)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a run is described by its start cycle and N, H, L; outputs follow
  // from the relative cycle number by plain arithmetic.
  bit     m_active = 1'b0;
  longint m_t0, m_n, m_h, m_l;
  longint m_hold = 0;
  longint d, tot, ep, eb, ed, es;

  always @(negedge clk) begin
    ep = 0; eb = 0; ed = 0; es = m_hold;
    if (m_active) begin
      d   = cyc - m_t0;
      tot = m_n * (m_h + m_l);
      if (d <= tot) begin
        ep = (((d - 1) % (m_h + m_l)) < m_h) ? 1 : 0;
        es = (d - 1) / (m_h + m_l) + 1;
        eb = 1;
      end else if (d == tot + 1) begin
        ed = 1; eb = 1; es = m_n;
      end else begin
        m_active = 1'b0; m_hold = m_n; es = m_n;
      end
    end
    if (chk_en) begin
      check_output("model_pulse", pulse, ep);
      check_output("model_busy", busy, eb);
      check_output("model_done", done, ed);
      check_output("model_sent", sent, es);
    end
    if (!rst_n) begin
      m_active = 1'b0; m_hold = 0;
    end else if (m_active) begin
      if (abort) begin m_active = 1'b0; m_hold = es; end
    end else if (start) begin
      m_active = 1'b1;
      m_t0 = cyc;
      m_n  = num_pulses;
      m_h  = (high_cycles == 0) ? 1 : high_cycles;
      m_l  = (low_cycles == 0) ? 1 : low_cycles;
    end
  end

  // Drives one accepted start in cycle 0 and leaves the bench in cycle 1.
  task automatic apply_stimulus(input int n, input int h, input int l);
    @(posedge clk); #1;
    num_pulses  = CW'(n);
    high_cycles = DW'(h);
    low_cycles  = DW'(l);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Observes cycles 1..budget; stops on the done cycle. Optional abort/reset
  // injection and start/config noise during the run.
  task automatic watch_run(input int budget, input int abort_at, input int reset_at, input bit noise,
                           output int done_rel, output int edges, output int busy_n,
                           output logic [63:0] pat);
    logic prev;
    prev = 1'b0; done_rel = -1; edges = 0; busy_n = 0; pat = '0;
    for (int rel = 1; rel <= budget; rel++) begin
      rst_n = (rel == reset_at) ? 1'b0 : 1'b1;
      abort = (rel == abort_at);
      if (noise) begin
        start       = 1'b1;
        num_pulses  = CW'($urandom_range(1, 9));
        high_cycles = DW'($urandom_range(0, 5));
        low_cycles  = DW'($urandom_range(0, 5));
      end
      @(negedge clk);
      if (pulse && !prev) edges++;
      prev = pulse;
      if (rel <= 64) pat[rel-1] = pulse;
      if (busy) busy_n++;
      if (done) begin
        done_rel = rel;
        break;
      end
      if (rel != budget) begin
        @(posedge clk); #1;
      end
    end
  endtask

  int          done_rel, edges, busy_n;
  logic [63:0] pat;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_pulses = '0; high_cycles = '0; low_cycles = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check_output("reset_pulse", pulse, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_sent", sent, 0);

    // Reset mid-run in cycle 7.
    apply_stimulus(5, 3, 2);
    watch_run(7, 0, 7, 1'b0, done_rel, edges, busy_n, pat);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_mid_pulse", pulse, 0);
    check_output("rst_mid_busy", busy, 0);
    check_output("rst_mid_sent", sent, 0);
    check_output("rst_mid_done", done, 0);

    // N=4, H=3, L=2.
    apply_stimulus(4, 3, 2);
    watch_run(40, 0, 0, 1'b0, done_rel, edges, busy_n, pat);
    check_output("n4_done_cycle", done_rel, 21);
    check_output("n4_edges", edges, 4);
    check_output("n4_sent", sent, 4);
    check_output("n4_pattern", pat[19:0], 20'b00111001110011100111);

    // N=0.
    apply_stimulus(0, 3, 2);
    watch_run(10, 0, 0, 1'b0, done_rel, edges, busy_n, pat);
    check_output("n0_done_cycle", done_rel, 1);
    check_output("n0_edges", edges, 0);
    check_output("n0_busy_cycles", busy_n, 1);
    check_output("n0_sent", sent, 0);

    // Zero durations behave as one cycle.
    apply_stimulus(3, 0, 0);
    watch_run(20, 0, 0, 1'b0, done_rel, edges, busy_n, pat);
    check_output("h0l0_pattern", pat[5:0], 6'b010101);
    check_output("h0l0_done_cycle", done_rel, 7);

    // Abort in cycle 9, restart in cycle 10.
    apply_stimulus(10, 2, 2);
    watch_run(9, 9, 0, 1'b0, done_rel, edges, busy_n, pat);
    check_output("abort_no_done", done_rel, -1);
    @(posedge clk); #1;
    abort = 1'b0;
    num_pulses = CW'(1); high_cycles = DW'(1); low_cycles = DW'(1);
    start = 1'b1;
    @(negedge clk);
    check_output("abort_busy_low", busy, 0);
    check_output("abort_sent_hold", sent, 3);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_output("restart_busy", busy, 1);
    watch_run(10, 0, 0, 1'b0, done_rel, edges, busy_n, pat);
    check_output("restart_done_cycle", done_rel, 2);

    // Start and config noise during the run and in the DONE cycle.
    apply_stimulus(2, 1, 1);
    watch_run(20, 0, 0, 1'b1, done_rel, edges, busy_n, pat);
    check_output("noise_done_cycle", done_rel, 5);
    check_output("noise_edges", edges, 2);
    check_output("noise_sent", sent, 2);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_output("noise_done_start_ignored", busy, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Programmable pulse-train generator: on a start command it emits a configured number of rectangular pulses with programmable high and low durations on a single registered output. It is the stimulus side of the pulse-counting path: it drives the `pulse` input of the rising-edge pulse counter in loopback and bring-up benches, and serves as an on-chip test source. It reports progress and completion so firmware can compare the generated count against the measured count.

## Interface
- `CNT_W`, 32: width of pulse-count configuration and `sent` counter.
- `DUR_W`, 16: width of high/low phase duration fields (in clk cycles).
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `abort` in 1: terminate a run in progress.
- `num_pulses` in CNT_W: number of pulses N; sampled on accepted start.
- `high_cycles` in DUR_W: high-phase length H; sampled on accepted start.
- `low_cycles` in DUR_W: low-phase length L; sampled on accepted start.
- `pulse` out 1: generated pulse train; registered.
- `busy` out 1: run in progress (including the DONE cycle).
- `done` out 1: one-cycle strobe on normal completion.
- `sent` out CNT_W: pulses emitted in current/last run.

## Operation
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE: pulse=0, busy=0. On start: latch N, H, L; clear `sent`. Go to HIGH if N≠0, else to DONE.
- H=0 is treated as H=1; L=0 is treated as L=1. A low gap of at least one cycle is always present, so a downstream edge detector sees every pulse.
- HIGH: pulse=1 for H cycles. On entry, `sent` increments by 1. After H cycles, go to LOW.
- LOW: pulse=0 for L cycles. After L cycles: if `sent`==N, go to DONE; else go to HIGH.
- DONE: pulse=0, busy=1, done=1 for exactly one cycle, then IDLE.
- abort in HIGH/LOW/DONE: next state is IDLE; pulse=0 and busy=0 from the next cycle. `done` is not asserted and `sent` holds its partial value. abort in IDLE has no effect.
- abort and start together in IDLE: start is accepted. abort has priority over start everywhere else.
- start while not in IDLE is ignored, including in the DONE cycle. Configuration inputs may change freely during a run without effect.
- `sent` holds its value after done until the next accepted start. The +1 on HIGH entry never wraps, because N ≤ 2^CNT_W−1.
- Phase timer: one DUR_W down-counter, loaded with H−1 or L−1 on phase entry; the phase ends when the counter reads 0.

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE, pulse=0, busy=0, done=0, sent=0, latched config=0. Reset mid-run takes effect the same way at the next edge.
- Let start be accepted at the edge ending cycle 0. For pulse k (k=0..N−1):
  - pulse=1 in cycles 1+k(H+L) through k(H+L)+H.
  - `sent`=k+1 from the first high cycle of pulse k.
- DONE (done=1) falls in cycle N(H+L)+1. busy=1 in cycles 1..N(H+L)+1. The earliest next start can be accepted in cycle N(H+L)+2.
- N=0: cycle 1 is DONE, with no pulse, sent=0.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `pulse_pkg`: FSM state encoding constants (IDLE/HIGH/LOW/DONE) and default CNT_W/DUR_W values, so the counter and generator benches share them.
- One sub-module: `phase_timer`, a loadable down-counter with load value and `expire` output, reusable elsewhere. FSM and `sent` counter stay in the top.

## Test plan
- Reset mid-run (N=5, H=3, L=2, rst_n low in cycle 7) -> next cycle pulse=0, busy=0, sent=0, done=0.
- N=4, H=3, L=2 -> pulse high in cycles 1–3, 6–8, 11–13, 16–18; done in cycle 21 only; sent=4; loopback pulse counter reads 4.
- N=0 -> done in cycle 1, pulse never high, sent=0, busy high only in cycle 1.
- N=3, H=0, L=0 -> behaves as H=L=1: pulse 1,0,1,0,1,0 in cycles 1–6; done in cycle 7.
- N=10, H=2, L=2, abort in cycle 9 -> pulse=0 and busy=0 from cycle 10; sent=3; no done. A start in cycle 10 is accepted.
- Start pulses during the run and in the DONE cycle, plus config changes mid-run (N=2, H=1, L=1) -> ignored: exactly 2 pulses, done in cycle 5.
